// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the two-port SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic {
    PortInstr = 1'b0,
    PortData  = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PortInstr) ? PortData : PortInstr;
  endfunction

  // Base must be aligned to size, so masking off the offset bits isolates the window.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] size,
                                         input logic [31:0] base);
    return (addr & ~(size - 32'd1)) == base;
  endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle between the instruction/data requesters, the arbiter and the SRAM.
interface sram_arbiter_if #(
  parameter int unsigned AddrWidth = 9
);

  logic                 instr_req_i;
  logic [31:0]          instr_addr_i;
  logic                 instr_gnt_o;
  logic                 instr_rvalid_o;
  logic [31:0]          instr_rdata_o;
  logic                 instr_err_o;

  logic                 data_req_i;
  logic                 data_we_i;
  logic [3:0]           data_be_i;
  logic [31:0]          data_addr_i;
  logic [31:0]          data_wdata_i;
  logic                 data_gnt_o;
  logic                 data_rvalid_o;
  logic                 data_err_o;
  logic [31:0]          data_rdata_o;

  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [3:0]           mem_be_o;
  logic [AddrWidth-1:0] mem_addr_o;
  logic [31:0]          mem_wdata_o;
  logic [31:0]          mem_rdata_i;

  modport slave (
    input  instr_req_i, instr_addr_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    output data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output instr_req_i, instr_addr_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o,
    output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
    input  data_gnt_o, data_rvalid_o, data_err_o, data_rdata_o,
    input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/sram_arb_rr.sv
// Two-request round-robin picker; priority only moves when both ports contend.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic req_instr,
  input  logic req_data,
  output logic gnt_instr,
  output logic gnt_data
);

  port_e prio_q;
  port_e prio_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= PortInstr;
    end else begin
      prio_q <= prio_d;
    end
  end

  always_comb begin
    gnt_instr = 1'b0;
    gnt_data  = 1'b0;
    prio_d    = prio_q;
    if (!rst_i) begin
      if (req_instr && req_data) begin
        gnt_instr = (prio_q == PortInstr);
        gnt_data  = (prio_q == PortData);
        prio_d    = other_port(prio_q);
      end else begin
        gnt_instr = req_instr;
        gnt_data  = req_data;
      end
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Single-cycle arbiter sharing one SRAM between instruction fetch and load/store,
// with a one-deep registered response stage and out-of-range error responses.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned MemSize   = 2048,
  parameter logic [31:0] MemStart  = 32'h0000_0000,
  parameter int unsigned AddrWidth = $clog2(MemSize / 4)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  sram_arbiter_if.slave  bus
);

  localparam logic [31:0] MemSizeW = 32'(MemSize);

  logic gnt_instr;
  logic gnt_data;
  logic gnt_any;
  logic instr_in_range;
  logic data_in_range;
  logic sel_in_range;

  port_e rsp_owner_q;
  logic  rsp_valid_q;
  logic  rsp_err_q;
  logic  rsp_we_q;
  logic  rsp_live;
  logic  rsp_has_data;

  sram_arb_rr u_rr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_instr (bus.instr_req_i),
    .req_data  (bus.data_req_i),
    .gnt_instr (gnt_instr),
    .gnt_data  (gnt_data)
  );

  always_comb begin
    instr_in_range = addr_in_range(bus.instr_addr_i, MemSizeW, MemStart);
    data_in_range  = addr_in_range(bus.data_addr_i, MemSizeW, MemStart);
    gnt_any        = gnt_instr | gnt_data;
    sel_in_range   = gnt_data ? data_in_range : instr_in_range;
  end

  always_comb begin
    bus.instr_gnt_o = gnt_instr;
    bus.data_gnt_o  = gnt_data;
    bus.mem_req_o   = 1'b0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    if (gnt_any && sel_in_range) begin
      bus.mem_req_o = 1'b1;
      if (gnt_data) begin
        bus.mem_we_o    = bus.data_we_i;
        bus.mem_be_o    = bus.data_be_i;
        bus.mem_addr_o  = bus.data_addr_i[AddrWidth+1:2];
        bus.mem_wdata_o = bus.data_we_i ? bus.data_wdata_i : '0;
      end else begin
        bus.mem_be_o   = '1;
        bus.mem_addr_o = bus.instr_addr_i[AddrWidth+1:2];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= PortInstr;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      rsp_valid_q <= gnt_any;
      rsp_owner_q <= gnt_data ? PortData : PortInstr;
      rsp_err_q   <= gnt_any & ~sel_in_range;
      rsp_we_q    <= gnt_data & bus.data_we_i;
    end
  end

  // The response stage clears only at the reset edge, so mask it while reset is held.
  always_comb begin
    rsp_live     = rsp_valid_q & ~rst_i;
    rsp_has_data = rsp_live & ~rsp_err_q & ~rsp_we_q;

    bus.instr_rvalid_o = rsp_live & (rsp_owner_q == PortInstr);
    bus.data_rvalid_o  = rsp_live & (rsp_owner_q == PortData);
    bus.instr_err_o    = bus.instr_rvalid_o & rsp_err_q;
    bus.data_err_o     = bus.data_rvalid_o & rsp_err_q;
    bus.instr_rdata_o  = (rsp_has_data && rsp_owner_q == PortInstr) ? bus.mem_rdata_i : '0;
    bus.data_rdata_o   = (rsp_has_data && rsp_owner_q == PortData)  ? bus.mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural one-cycle-latency SRAM.
module tb_sram_arbiter;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  logic [31:0] mem [512];

  sram_arbiter_if #(.AddrWidth(9)) bus ();

  sram_arbiter #(
    .MemSize  (2048),
    .MemStart (32'h0000_0000)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // SRAM model; non-read cycles return a poison pattern to expose unmasked rdata.
  always @(posedge clk_i) begin
    if (bus.mem_req_o && bus.mem_we_o) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.mem_be_o[b]) mem[bus.mem_addr_o][b*8 +: 8] <= bus.mem_wdata_o[b*8 +: 8];
      end
    end
    bus.mem_rdata_i <= (bus.mem_req_o && !bus.mem_we_o) ? mem[bus.mem_addr_o] : 32'hBAD0_BAD0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.instr_req_i  = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_be_i    = '0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
  endtask

  task automatic drive_instr(input logic [31:0] addr);
    bus.instr_req_i  = 1'b1;
    bus.instr_addr_i = addr;
  endtask

  task automatic drive_data(input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = we;
    bus.data_be_i    = be;
    bus.data_addr_i  = addr;
    bus.data_wdata_i = wdata;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h20] = 32'hDEAD_0013;
    mem[9'h40] = 32'h1122_3344;
    mem[9'h41] = 32'hCAFE_F00D;
    bus.mem_rdata_i = '0;
    drive_idle();

    // Reset held with both ports requesting: nothing may be granted.
    drive_instr(32'h80);
    drive_data(1'b0, 4'hF, 32'h104, 32'h0);
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_instr_gnt", bus.instr_gnt_o, 0);
    chk("rst_data_gnt", bus.data_gnt_o, 0);
    chk("rst_mem_req", bus.mem_req_o, 0);
    chk("rst_mem_we", bus.mem_we_o, 0);
    chk("rst_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("rst_data_rvalid", bus.data_rvalid_o, 0);

    // Instruction fetch at 0x80.
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_idle();
    drive_instr(32'h80);
    #1;
    chk("if_gnt", bus.instr_gnt_o, 1);
    chk("if_data_gnt", bus.data_gnt_o, 0);
    chk("if_mem_req", bus.mem_req_o, 1);
    chk("if_mem_addr", bus.mem_addr_o, 32'h20);
    chk("if_mem_we", bus.mem_we_o, 0);
    chk("if_mem_be", bus.mem_be_o, 32'hF);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("if_rvalid", bus.instr_rvalid_o, 1);
    chk("if_rdata", bus.instr_rdata_o, 32'hDEAD_0013);
    chk("if_err", bus.instr_err_o, 0);
    chk("if_data_rvalid", bus.data_rvalid_o, 0);
    chk("if_mem_req_idle", bus.mem_req_o, 0);

    // Byte write to 0x100.
    @(negedge clk_i);
    drive_data(1'b1, 4'b0001, 32'h100, 32'h0000_000A);
    #1;
    chk("wr_gnt", bus.data_gnt_o, 1);
    chk("wr_mem_we", bus.mem_we_o, 1);
    chk("wr_mem_be", bus.mem_be_o, 32'h1);
    chk("wr_mem_addr", bus.mem_addr_o, 32'h40);
    chk("wr_mem_wdata", bus.mem_wdata_o, 32'h0000_000A);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("wr_rvalid", bus.data_rvalid_o, 1);
    chk("wr_rdata", bus.data_rdata_o, 0);
    chk("wr_err", bus.data_err_o, 0);
    chk("wr_instr_rvalid", bus.instr_rvalid_o, 0);

    // Read back: only byte 0 of the word should have changed.
    @(negedge clk_i);
    drive_data(1'b0, 4'hF, 32'h100, 32'h0);
    #1;
    chk("rb_mem_we", bus.mem_we_o, 0);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("rb_rvalid", bus.data_rvalid_o, 1);
    chk("rb_rdata", bus.data_rdata_o, 32'h1122_330A);

    // Out-of-range load.
    @(negedge clk_i);
    drive_data(1'b0, 4'hF, 32'h0001_0000, 32'h0);
    #1;
    chk("oor_gnt", bus.data_gnt_o, 1);
    chk("oor_mem_req", bus.mem_req_o, 0);
    chk("oor_mem_addr", bus.mem_addr_o, 0);
    chk("oor_mem_be", bus.mem_be_o, 0);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("oor_rvalid", bus.data_rvalid_o, 1);
    chk("oor_err", bus.data_err_o, 1);
    chk("oor_rdata", bus.data_rdata_o, 0);

    // Fresh reset, then four consecutive ties alternate instr/data.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    drive_instr(32'h80);
    drive_data(1'b0, 4'hF, 32'h104, 32'h0);
    #1;
    chk("rr1_instr_gnt", bus.instr_gnt_o, 1);
    chk("rr1_data_gnt", bus.data_gnt_o, 0);
    chk("rr1_mem_addr", bus.mem_addr_o, 32'h20);
    @(negedge clk_i);
    #1;
    chk("rr2_data_gnt", bus.data_gnt_o, 1);
    chk("rr2_instr_gnt", bus.instr_gnt_o, 0);
    chk("rr2_mem_addr", bus.mem_addr_o, 32'h41);
    chk("rr2_instr_rvalid", bus.instr_rvalid_o, 1);
    chk("rr2_instr_rdata", bus.instr_rdata_o, 32'hDEAD_0013);
    chk("rr2_data_rvalid", bus.data_rvalid_o, 0);
    @(negedge clk_i);
    #1;
    chk("rr3_instr_gnt", bus.instr_gnt_o, 1);
    chk("rr3_data_rvalid", bus.data_rvalid_o, 1);
    chk("rr3_data_rdata", bus.data_rdata_o, 32'hCAFE_F00D);
    chk("rr3_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("rr3_instr_rdata", bus.instr_rdata_o, 0);
    @(negedge clk_i);
    #1;
    chk("rr4_data_gnt", bus.data_gnt_o, 1);
    chk("rr4_instr_rvalid", bus.instr_rvalid_o, 1);
    chk("rr4_instr_rdata", bus.instr_rdata_o, 32'hDEAD_0013);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("rr5_data_rvalid", bus.data_rvalid_o, 1);
    chk("rr5_data_rdata", bus.data_rdata_o, 32'hCAFE_F00D);
    chk("rr5_instr_gnt", bus.instr_gnt_o, 0);
    chk("rr5_data_gnt", bus.data_gnt_o, 0);

    // Tie grants instr and hands priority to data; reset must drop the response and restore instr priority.
    @(negedge clk_i);
    drive_instr(32'h80);
    drive_data(1'b0, 4'hF, 32'h104, 32'h0);
    #1;
    chk("pr_tie_instr_gnt", bus.instr_gnt_o, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive_idle();
    #1;
    chk("pr_rst_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("pr_rst_instr_rdata", bus.instr_rdata_o, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("pr_post_instr_rvalid", bus.instr_rvalid_o, 0);
    chk("pr_post_data_rvalid", bus.data_rvalid_o, 0);
    @(negedge clk_i);
    drive_instr(32'h80);
    drive_data(1'b0, 4'hF, 32'h104, 32'h0);
    #1;
    chk("pr_tie2_instr_gnt", bus.instr_gnt_o, 1);
    chk("pr_tie2_data_gnt", bus.data_gnt_o, 0);
    @(negedge clk_i);
    drive_idle();
    #1;
    chk("pr_tie2_rvalid", bus.instr_rvalid_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
